// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to packed BCD converter with digit mux
module bin2bcd_seq #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  input  logic [2:0]            digit_sel,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [3:0]            digit
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int CW = $clog2(W);
  logic [0:0]          state;
  logic [W-1:0]        bin_r;
  logic [4*DIGITS-1:0] scr, adj, scr_n;
  logic [CW-1:0]       cnt;
  logic [3:0]          nib [8];
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i +: 4] = scr[4*i +: 4] >= 4'd5 ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
  end
  assign scr_n = {adj[4*DIGITS-2:0], bin_r[W-1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      bcd   <= '0;
      scr   <= '0;
      bin_r <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= SHIFT;
          bin_r <= bin;
          scr   <= '0;
          cnt   <= '0;
        end
      end else begin
        scr   <= scr_n;
        bin_r <= {bin_r[W-2:0], 1'b0};
        cnt   <= cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          state <= IDLE;
          bcd   <= scr_n;
          done  <= 1'b1;
        end
      end
    end
  end
  for (genvar d = 0; d < 8; d++) begin : g_nib
    if (d < DIGITS) begin : g_v
      assign nib[d] = bcd[4*d +: 4];
    end else begin : g_z
      assign nib[d] = 4'h0;
    end
  end
  assign busy  = state == SHIFT;
  assign digit = nib[digit_sel];
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random checks of bin2bcd_seq against a decimal reference model
module tb_bin2bcd_seq;
  logic        clk = 0, rst = 1, start = 0;
  logic [15:0] bin = 0;
  logic [2:0]  digit_sel = 0;
  logic        busy, done;
  logic [19:0] bcd;
  logic [3:0]  digit;
  int tests = 0, fails = 0, dcnt = 0, n, d0;
  logic en = 0;
  logic m_busy = 0, m_done = 0;
  logic [31:0] m_bcd = 0, m_pend = 0, e_dig;
  int m_left = 0;
  logic [3:0] exp_dig [5] = '{4'd5, 4'd3, 4'd5, 4'd5, 4'd6};

  bin2bcd_seq #(.W(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .digit_sel(digit_sel),
    .busy(busy), .done(done), .bcd(bcd), .digit(digit)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] r = 0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (done !== 1'b1 && k < 40);
  endtask

  task automatic go(logic [15:0] v);
    bin = v;
    start = 1;
    cyc(1);
    start = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_bcd = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_bcd = m_pend;
        end
      end else if (start) begin
        m_busy = 1; m_left = 16; m_pend = to_bcd(int'(bin));
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      e_dig = digit_sel < 3'd5 ? {28'd0, m_bcd[4*digit_sel +: 4]} : 32'd0;
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("bcd", {12'd0, bcd}, m_bcd);
      chk("digit", {28'd0, digit}, e_dig);
      if (done === 1'b1) dcnt++;
    end
  end

  initial begin
    chk("model_65535", to_bcd(65535), 32'h65535);
    chk("model_1234", to_bcd(1234), 32'h01234);
    chk("model_0", to_bcd(0), 32'h0);
    cyc(2);
    rst = 0;
    en = 1;
    cyc(1);
    chk("rst_bcd", {12'd0, bcd}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_digit", {28'd0, digit}, 32'd0);
    d0 = dcnt;
    go(16'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("t1_lat", n, 16);
    chk("t1_bcd", {12'd0, bcd}, 32'h0);
    cyc(2);
    chk("t1_dcnt", dcnt - d0, 1);
    go(16'd65535);
    wait_done(n);
    chk("t2_lat", n, 16);
    chk("t2_bcd", {12'd0, bcd}, 32'h65535);
    for (int i = 0; i < 5; i++) begin
      digit_sel = 3'(i);
      #1;
      chk("t2_digit", {28'd0, digit}, {28'd0, exp_dig[i]});
    end
    digit_sel = 3'd6;
    #1;
    chk("t2_digit6", {28'd0, digit}, 32'd0);
    digit_sel = 0;
    cyc(2);
    d0 = dcnt;
    go(16'd1234);
    cyc(5);
    go(16'd9999);
    wait_done(n);
    chk("t3_bcd", {12'd0, bcd}, 32'h01234);
    cyc(20);
    chk("t3_dcnt", dcnt - d0, 1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    go(16'd7);
    wait_done(n);
    chk("t4_bcd7", {12'd0, bcd}, 32'h7);
    go(16'd9);
    chk("t4_hold", {12'd0, bcd}, 32'h7);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    chk("t4_lat", n, 16);
    chk("t4_bcd9", {12'd0, bcd}, 32'h9);
    cyc(2);
    go(16'd42);
    wait_done(n);
    chk("t5_bcd42", {12'd0, bcd}, 32'h42);
    cyc(1);
    go(16'd500);
    cyc(7);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("t5_bcd", {12'd0, bcd}, 32'h0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    d0 = dcnt;
    cyc(20);
    chk("t5_nodone", dcnt - d0, 0);
    for (int i = 0; i < 1000; i++) begin
      go(16'($urandom_range(0, 65535)));
      wait_done(n);
      chk("rnd_lat", n, 16);
      chk("rnd_bcd", {12'd0, bcd}, to_bcd(int'(bin)));
    end
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
